// File: rtl/cu_pkg.sv
// Shared control-unit definitions: fetch FSM states and instruction constants.
package cu_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT_MEM,
    ISSUE,
    WAIT_DEC,
    HALT
  } if_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0003;

endpackage : cu_pkg

// File: rtl/cu_if_timeout.sv
// Loadable down-counter with synchronous clear and an expire flag.
// expired_o is high while the count sits at 1, i.e. during the last cycle
// of a window of load_val_i cycles that started when the counter was loaded.
module cu_if_timeout #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement; stops at zero.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == W'(1));

endmodule : cu_if_timeout

// File: rtl/cu_if_fetch.sv
// Instruction-fetch initiator: fetches the word at pc, hands it to decode
// as Cu_IR with a one-cycle decode_start, then advances pc by the decoder's
// increment or jumps to a redirect target.
// Optional build macro CU_IF_PERF_CNT_EN adds fetch/stall counters.
module cu_if_fetch
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        soc_clk,
  input  logic        IF_reset,
  input  logic        IF_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Cu_IR,
  output logic        decode_start,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        invalid_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        fetch_fault
`ifdef CU_IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [7:0] TMO_LOAD = 8'(MEM_TIMEOUT);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        fault_q, fault_d;
  logic        tmo_clr, tmo_load, tmo_dec, tmo_expired;

  // Watchdog for the memory response; loaded as WAIT_MEM is entered.
  cu_if_timeout #(.W(8)) u_timeout (
    .clk_i      (soc_clk),
    .rst_i      (IF_reset),
    .clr_i      (tmo_clr),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmo_dec),
    .expired_o  (tmo_expired)
  );

  // Next-state, datapath updates and the decode_start pulse.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    fault_d      = fault_q;
    tmo_clr      = 1'b0;
    tmo_load     = 1'b0;
    tmo_dec      = 1'b0;
    decode_start = 1'b0;
    if (IF_reset) begin
      // Registers are reset in the sequential block; keep outputs quiet.
    end else if (redirect_valid) begin
      // Flush: any same-cycle mem_ack or IDU_ready is dropped.
      pc_d    = redirect_pc;
      fault_d = 1'b0;
      tmo_clr = 1'b1;
      state_d = REQ;
    end else begin
      case (state_q)
        REQ: begin
          if (!IF_stall) begin
            if ((pc_q & INSTR_ALIGN_MASK) != '0) begin
              fault_d = 1'b1;
              state_d = HALT;
            end else begin
              tmo_load = 1'b1;
              state_d  = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Stall does not hold off capture of an outstanding response.
          tmo_dec = 1'b1;
          if (mem_ack) begin
            ir_d    = mem_rdata;
            state_d = ISSUE;
          end else if (tmo_expired) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
        ISSUE: begin
          if (!IF_stall) begin
            decode_start = 1'b1;
            state_d      = WAIT_DEC;
          end
        end
        WAIT_DEC: begin
          if (IDU_ready) begin
            if (invalid_instruction) begin
              fault_d = 1'b1;
              state_d = HALT;
            end else begin
              pc_d    = pc_q + pc_increment;
              state_d = REQ;
            end
          end
        end
        HALT: begin
          // Frozen until redirect or reset.
        end
        default: state_d = REQ;
      endcase
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge soc_clk) begin
    if (IF_reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req     = (state_q == WAIT_MEM);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign Cu_IR       = ir_q;
  assign fetch_fault = fault_q;

`ifdef CU_IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        fetch_accept;

  assign fetch_accept = (state_q == WAIT_MEM) && mem_ack && !redirect_valid;

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge soc_clk) begin
    if (IF_reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (fetch_accept && (fetch_count_q != '1)) fetch_count_q <= fetch_count_q + 32'd1;
      if (IF_stall && (stall_count_q != '1))     stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule : cu_if_fetch

// File: tb/tb_cu_if_fetch.sv
// Self-checking bench for cu_if_fetch: fetched words are pushed to a
// scoreboard when acked and popped when decode_start is observed.
module tb_cu_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        IF_reset, IF_stall, mem_ack, IDU_ready, invalid_instruction, redirect_valid;
  logic [31:0] mem_rdata, pc_increment, redirect_pc;
  logic        mem_req, decode_start, fetch_fault;
  logic [31:0] mem_addr, Cu_IR, pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_t;

  fetch_t      sb_q[$];
  logic [31:0] exp_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  cu_if_fetch #(.RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
    .soc_clk             (clk),
    .IF_reset            (IF_reset),
    .IF_stall            (IF_stall),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .Cu_IR               (Cu_IR),
    .decode_start        (decode_start),
    .IDU_ready           (IDU_ready),
    .pc_increment        (pc_increment),
    .invalid_instruction (invalid_instruction),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .pc                  (pc),
    .fetch_fault         (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return the word for the outstanding request; expectation recorded first.
  task automatic do_ack(input logic [31:0] data);
    sb_q.push_back('{pc: exp_pc, ir: data});
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack   = 1'b0;
  endtask

  // Expect a single decode_start carrying the next scoreboard entry.
  task automatic check_issue(input string tag);
    fetch_t e;
    check({tag, "_dstart"}, 32'(decode_start), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_ir"}, Cu_IR, e.ir);
      check({tag, "_pc"}, pc, e.pc);
    end
    step();
    check({tag, "_dstart_off"}, 32'(decode_start), 32'd0);
  endtask

  // Complete decode; pc moves at M+1 and the next request appears at M+2.
  task automatic idu(input string tag, input logic [31:0] inc);
    IDU_ready    = 1'b1;
    pc_increment = inc;
    exp_pc       = exp_pc + inc;
    step();
    IDU_ready = 1'b0;
    check({tag, "_req_m1"}, 32'(mem_req), 32'd0);
    check({tag, "_pc"}, pc, exp_pc);
    step();
    check({tag, "_req_m2"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, mem_addr, exp_pc);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_pc         = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    IF_reset = 1'b1; IF_stall = 1'b0; mem_ack = 1'b0; IDU_ready = 1'b0;
    invalid_instruction = 1'b0; redirect_valid = 1'b0;
    mem_rdata = '0; pc_increment = '0; redirect_pc = '0;
    exp_pc = 32'h0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", Cu_IR, NOP);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_dstart", 32'(decode_start), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // Basic fetch with the memory answering after 3 cycles.
    IF_reset = 1'b0;
    step();
    check("f1_req", 32'(mem_req), 32'd1);
    check("f1_addr", mem_addr, 32'h0);
    step(); step();
    check("f1_addr_stable", mem_addr, 32'h0);
    do_ack(32'h0050_0093);
    check_issue("f1");
    idu("f1", 32'd4);

    // Stall across ISSUE: word captured, pulse held off, pc unchanged.
    IF_stall = 1'b1;
    do_ack(32'h0010_0113);
    for (int i = 0; i < 5; i++) begin
      check("stall_dstart", 32'(decode_start), 32'd0);
      check("stall_pc", pc, exp_pc);
      if (i < 4) step();
    end
    IF_stall = 1'b0;
    #1;
    check_issue("stall");
    idu("stall", 32'd4);

    // Redirect coinciding with mem_ack: word dropped, refetch at target.
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    redirect(32'h100);
    mem_ack = 1'b0;
    check("rd_dstart", 32'(decode_start), 32'd0);
    check("rd_req", 32'(mem_req), 32'd0);
    check("rd_pc", pc, 32'h100);
    step();
    check("rd_req2", 32'(mem_req), 32'd1);
    check("rd_addr", mem_addr, 32'h100);
    check("rd_dstart2", 32'(decode_start), 32'd0);
    do_ack(32'h00A0_0113);
    check_issue("rd");
    idu("rd", 32'd4);

    // Memory never answers: 16 cycles of mem_req, then fault and HALT.
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) cnt++;
      else break;
    end
    check("tmo_cycles", 32'(cnt), 32'd16);
    check("tmo_fault", 32'(fetch_fault), 32'd1);
    check("tmo_req", 32'(mem_req), 32'd0);
    step(); step(); step();
    check("halt_fault", 32'(fetch_fault), 32'd1);
    check("halt_req", 32'(mem_req), 32'd0);
    check("halt_dstart", 32'(decode_start), 32'd0);
    redirect(32'h0);
    check("tmo_clr_fault", 32'(fetch_fault), 32'd0);
    step();
    check("tmo_refetch_req", 32'(mem_req), 32'd1);
    check("tmo_refetch_addr", mem_addr, 32'h0);
    do_ack(32'h0020_0193);
    check_issue("tmo");
    idu("tmo", 32'd4);

    // Misaligned redirect target.
    redirect(32'h102);
    check("mis_pc", pc, 32'h102);
    step();
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    step(); step();
    check("mis_req_hold", 32'(mem_req), 32'd0);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    do_ack(32'h0030_0213);
    check_issue("wrap");
    idu("wrap", 32'd4);
    check("wrap_zero", mem_addr, 32'h0);

    // Reset while waiting on decode.
    redirect(32'h200);
    step();
    do_ack(32'h0040_0293);
    check_issue("mid");
    IF_reset = 1'b1;
    step();
    IF_reset = 1'b0;
    exp_pc = 32'h0;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_ir", Cu_IR, NOP);
    check("mid_rst_dstart", 32'(decode_start), 32'd0);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    step();
    check("mid_rst_req2", 32'(mem_req), 32'd1);
    check("mid_rst_addr", mem_addr, 32'h0);

    // Decoder reports an invalid instruction.
    do_ack(32'hFFFF_FFFF);
    check_issue("inv");
    IDU_ready = 1'b1; invalid_instruction = 1'b1; pc_increment = 32'd4;
    step();
    IDU_ready = 1'b0; invalid_instruction = 1'b0;
    check("inv_fault", 32'(fetch_fault), 32'd1);
    check("inv_pc", pc, 32'h0);
    step();
    check("inv_req", 32'(mem_req), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cu_if_fetch

// File: doc/cu_if_fetch.md
Name: cu_if_fetch

Overview:
- Instruction-fetch initiator for the control unit.
- Reads the instruction at the current PC from instruction memory, latches it as Cu_IR, and pulses decode_start to the decode stage.
- Waits for IDU_ready, then advances PC by the decoder-supplied pc_increment, or by a redirect target.
- Sits between instruction memory and the decode stage, driving the decode stage's Cu_IR/decode_start inputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles in WAIT_MEM before fetch_fault; range 1..255.

Ports:
- soc_clk  in  1  system clock
- IF_reset  in  1  synchronous active-high reset
- IF_stall  in  1  hold current state; no new mem_req, no decode_start
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  32  word-aligned fetch address (= pc)
- mem_ack  in  1  one-cycle read-data-valid
- mem_rdata  in  32  instruction word, valid with mem_ack
- Cu_IR  out  32  latched instruction to decode
- decode_start  out  1  one-cycle pulse, Cu_IR valid
- IDU_ready  in  1  decode of current Cu_IR complete
- pc_increment  in  32  PC delta from decode, sampled with IDU_ready
- invalid_instruction  in  1  decode error, sampled with IDU_ready
- redirect_valid  in  1  flush and load redirect_pc (branch/jump/trap)
- redirect_pc  in  32  new PC
- pc  out  32  PC of the instruction in Cu_IR
- fetch_fault  out  1  sticky; misaligned PC, timeout, or invalid_instruction

Behaviour:
Reset values:
- pc = RESET_PC; Cu_IR = 32'h0000_0013 (NOP).
- mem_req, decode_start, fetch_fault = 0.
- State = REQ. All reset effects are synchronous only.

States:
- REQ: if !IF_stall and pc[1:0]==0, assert mem_req and go to WAIT_MEM. If pc[1:0]!=0, set fetch_fault and go to HALT.
- WAIT_MEM: mem_req stays high; timeout counter increments each cycle.
  - On mem_ack: Cu_IR <= mem_rdata, mem_req <= 0, go to ISSUE.
  - When the counter reaches MEM_TIMEOUT: fetch_fault=1, go to HALT.
  - IF_stall does not block mem_ack capture.
- ISSUE: if !IF_stall, decode_start=1 for exactly one cycle, then go to WAIT_DEC.
- WAIT_DEC: on IDU_ready:
  - If invalid_instruction: fetch_fault=1, go to HALT.
  - Otherwise pc <= pc + pc_increment (32-bit modular, wrap allowed), go to REQ.
- HALT: outputs frozen. Only redirect_valid or IF_reset leaves HALT.

Redirect:
- redirect_valid in any state: pc <= redirect_pc, mem_req <= 0, decode_start <= 0, timeout counter cleared, fetch_fault cleared, next state REQ.
- A mem_ack in the same cycle is discarded.
- A pending IDU_ready in the same cycle is ignored.

Priority: IF_reset > redirect_valid > IF_stall > normal progress.

Latency:
- mem_ack at cycle N gives decode_start at N+1 (no stall).
- IDU_ready at M gives mem_req at M+2 (update PC, then REQ).

Handshake rules:
- mem_addr is stable while mem_req is high.
- Cu_IR and pc are stable from decode_start until the cycle after IDU_ready.
- A mem_ack seen outside WAIT_MEM is ignored.

Optional Feature:
- CU_IF_PERF_CNT_EN defined:
  - Adds outputs fetch_count[31:0] (increments on each accepted mem_ack) and stall_count[31:0] (increments each cycle IF_stall=1).
  - Both reset to 0 on IF_reset, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package cu_pkg:
  - typedef enum if_state_t {REQ, WAIT_MEM, ISSUE, WAIT_DEC, HALT}
  - constant NOP_INSTR = 32'h0000_0013
  - constant INSTR_ALIGN_MASK = 32'h3
- One sub-module is natural: cu_if_timeout, a loadable down-counter with clear and expire flag, also reusable by the other CU stages.

Test Plan:
- Reset, then mem_ack with 32'h00500093 after 3 cycles -> mem_addr=0, Cu_IR=32'h00500093, single decode_start pulse; IDU_ready with pc_increment=4 -> next mem_addr=4.
- IF_stall held 5 cycles in ISSUE -> no decode_start during stall; exactly one pulse the cycle after release; pc unchanged.
- redirect_valid with redirect_pc=32'h100 in the same cycle as mem_ack -> data dropped, next mem_addr=32'h100, no decode_start for the dropped word.
- No mem_ack with MEM_TIMEOUT=16 -> fetch_fault=1 after 16 WAIT_MEM cycles, mem_req low, HALT held; redirect to 32'h0 clears the fault and refetches.
- redirect_pc=32'h102 -> fetch_fault=1, no mem_req issued; pc=32'hFFFF_FFFC with pc_increment=4 -> next pc=0 (wrap).
- IF_reset asserted mid-WAIT_DEC -> next cycle pc=RESET_PC, Cu_IR=NOP, decode_start=0, state REQ.
